// File: rtl/banco_reg_param_if.sv
// banco_reg_param_if: bundles the register-bank read/write bus.
// Parameters: WIDTH (data bits), ADDR_W (address bits).
// Signals:
//   RegWrite  - write enable from the writeback stage
//   RA1, RA2  - read addresses from the decode stage
//   AW        - write address
//   WriteData - write data
//   DR1, DR2  - combinational read data
//   Ready     - bank cleared and accepting writes
//   WrDrop    - one-cycle pulse, write discarded during CLEAR
// Modports: master (datapath side), slave (register bank side).
interface banco_reg_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [ADDR_W-1:0] AW;
    logic [WIDTH-1:0]  WriteData;
    logic [WIDTH-1:0]  DR1;
    logic [WIDTH-1:0]  DR2;
    logic              Ready;
    logic              WrDrop;

    modport master (
        output RegWrite,
        output RA1,
        output RA2,
        output AW,
        output WriteData,
        input  DR1,
        input  DR2,
        input  Ready,
        input  WrDrop
    );

    modport slave (
        input  RegWrite,
        input  RA1,
        input  RA2,
        input  AW,
        input  WriteData,
        output DR1,
        output DR2,
        output Ready,
        output WrDrop
    );
endinterface

// File: rtl/banco_reg_param.sv
// banco_reg_param: parametrised register bank, 2 combinational read
// ports, 1 clocked write port, self-clearing after every reset.
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - synchronous, active-high reset
//   bus - banco_reg_param_if.slave (RegWrite, RA1, RA2, AW,
//         WriteData in; DR1, DR2, Ready, WrDrop out)
// Parameters: WIDTH, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG.
// Optional macro BANCO_BYPASS_EN: forwards an accepted write to a
// read port addressing the same register in the same cycle.
module banco_reg_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    banco_reg_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;
    logic              wr_drop;
    logic              wr_drop_nxt;
    logic              clr_en;
    logic              wr_ok;
    logic              zero_aw;
    logic              zero_ra1;
    logic              zero_ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  regs [DEPTH];

    // Register 0 is only special when ZERO_REG is set.
    assign zero_aw  = (ZERO_REG != 0) && (bus.AW == '0);
    assign zero_ra1 = (ZERO_REG != 0) && (bus.RA1 == '0);
    assign zero_ra2 = (ZERO_REG != 0) && (bus.RA2 == '0);

    // A write commits only in RUN and loses to a same-cycle reset.
    assign wr_ok = (state == RUN) && !rst && bus.RegWrite && !zero_aw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            wr_drop <= wr_drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        wr_drop_nxt = 1'b0;
        clr_en      = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_en      = 1'b1;
                // Index wraps back to 0 on the last clear edge.
                clr_idx_nxt = clr_idx + 1'b1;
                wr_drop_nxt = bus.RegWrite;
                if (clr_idx == LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Storage has no reset; the sequencer zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                regs[clr_idx] <= '0;
            end else if (wr_ok) begin
                regs[bus.AW] <= bus.WriteData;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if ((state == RUN) && !zero_ra1) begin
            rd1 = regs[bus.RA1];
`ifdef BANCO_BYPASS_EN
            if (wr_ok && (bus.AW == bus.RA1)) begin
                rd1 = bus.WriteData;
            end
`endif
        end
    end

    always_comb begin
        rd2 = '0;
        if ((state == RUN) && !zero_ra2) begin
            rd2 = regs[bus.RA2];
`ifdef BANCO_BYPASS_EN
            if (wr_ok && (bus.AW == bus.RA2)) begin
                rd2 = bus.WriteData;
            end
`endif
        end
    end

    assign bus.DR1    = rd1;
    assign bus.DR2    = rd2;
    assign bus.Ready  = (state == RUN);
    assign bus.WrDrop = wr_drop;
endmodule

// File: tb/tb_banco_reg_param.sv
// tb_banco_reg_param: scoreboard bench for banco_reg_param,
// one instance with ZERO_REG=1 and one with ZERO_REG=0.
module tb_banco_reg_param;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        string            tag;
        int               sel;
        logic [WIDTH-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [WIDTH-1:0]  mdl_z [DEPTH];
    logic [WIDTH-1:0]  mdl_n [DEPTH];
    bit                running  = 1'b0;
    int                clr_cnt  = 0;
    bit                exp_drop = 1'b0;
    logic              cur_rw   = 1'b0;
    logic [ADDR_W-1:0] cur_aw   = '0;
    logic [WIDTH-1:0]  cur_wd   = '0;

    always #5 clk = ~clk;

    banco_reg_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_z ();
    banco_reg_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_n ();

    banco_reg_param #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)
    ) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z.slave)
    );

    banco_reg_param #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0)
    ) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n.slave)
    );

    task automatic chk(input string tag,
                       input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] observe(input int sel);
        case (sel)
            0: return bus_z.DR1;
            1: return bus_z.DR2;
            2: return WIDTH'(bus_z.Ready);
            3: return WIDTH'(bus_z.WrDrop);
            4: return bus_n.DR1;
            5: return bus_n.DR2;
            6: return WIDTH'(bus_n.Ready);
            7: return WIDTH'(bus_n.WrDrop);
            default: return 'x;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] model_rd(input bit zero,
                                                  input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (!running) return '0;
        if (zero && a == '0) return '0;
        v = zero ? mdl_z[a] : mdl_n[a];
`ifdef BANCO_BYPASS_EN
        if (!rst && cur_rw && cur_aw == a) v = cur_wd;
`endif
        return v;
    endfunction

    task automatic push(input string tag, input int sel,
                        input logic [WIDTH-1:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic rw,
                         input logic [ADDR_W-1:0] aw,
                         input logic [WIDTH-1:0] wd,
                         input logic [ADDR_W-1:0] ra1,
                         input logic [ADDR_W-1:0] ra2);
        @(negedge clk);
        rst    = r;
        cur_rw = rw;
        cur_aw = aw;
        cur_wd = wd;
        bus_z.RegWrite = rw;  bus_n.RegWrite = rw;
        bus_z.AW = aw;        bus_n.AW = aw;
        bus_z.WriteData = wd; bus_n.WriteData = wd;
        bus_z.RA1 = ra1;      bus_n.RA1 = ra1;
        bus_z.RA2 = ra2;      bus_n.RA2 = ra2;
        push("dr1_z", 0, model_rd(1'b1, ra1));
        push("dr2_z", 1, model_rd(1'b1, ra2));
        push("rdy_z", 2, WIDTH'(running));
        push("drop_z", 3, WIDTH'(exp_drop));
        push("dr1_n", 4, model_rd(1'b0, ra1));
        push("dr2_n", 5, model_rd(1'b0, ra2));
        push("rdy_n", 6, WIDTH'(running));
        push("drop_n", 7, WIDTH'(exp_drop));
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            running  = 1'b0;
            clr_cnt  = 0;
            exp_drop = 1'b0;
        end else if (!running) begin
            exp_drop = cur_rw;
            clr_cnt++;
            if (clr_cnt == DEPTH) begin
                running = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    mdl_z[i] = '0;
                    mdl_n[i] = '0;
                end
            end
        end else begin
            exp_drop = 1'b0;
            if (cur_rw) begin
                if (cur_aw != '0) mdl_z[cur_aw] = cur_wd;
                mdl_n[cur_aw] = cur_wd;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic rw,
                         input logic [ADDR_W-1:0] aw,
                         input logic [WIDTH-1:0] wd,
                         input logic [ADDR_W-1:0] ra1,
                         input logic [ADDR_W-1:0] ra2);
        drive(r, rw, aw, wd, ra1, ra2);
        drain();
        tick();
    endtask

    initial begin
        bus_z.RegWrite = 1'b0; bus_n.RegWrite = 1'b0;
        bus_z.AW = '0;         bus_n.AW = '0;
        bus_z.WriteData = '0;  bus_n.WriteData = '0;
        bus_z.RA1 = '0;        bus_n.RA1 = '0;
        bus_z.RA2 = '0;        bus_n.RA2 = '0;

        // reset held for three edges
        tick();
        repeat (2) cycle(1'b1, 1'b0, '0, '0, '0, '0);

        // clear sequence, attempted write on the 10th clear edge
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b0, k == 10, 7, 32'hA5A5A5A5,
                  ADDR_W'(k), ADDR_W'(DEPTH - 1 - k));
            if (k == 11) push("wrdrop_pulse", 3, 1);
            if (k == 12) push("wrdrop_end", 3, 0);
            if (k == DEPTH) push("rdy_before_last", 2, 0);
            drain();
            tick();
        end

        // bank must read all zeros once ready
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
            if (i == 0) push("rdy_up", 2, 1);
            if (i == 7) push("r7_cleared", 0, 0);
            drain();
            tick();
        end

        // plain write, read back next cycle
        cycle(1'b0, 1'b1, 5, 32'hDEADBEEF, 6, 5);
        drive(1'b0, 1'b0, '0, '0, 5, 5);
        push("r5_p1", 0, 32'hDEADBEEF);
        push("r5_p2", 1, 32'hDEADBEEF);
        push("r5_p1_n", 4, 32'hDEADBEEF);
        drain();
        tick();
        drive(1'b0, 1'b0, '0, '0, 6, 5);
        push("r6_zero", 0, 0);
        drain();
        tick();

        // write to register 0
        cycle(1'b0, 1'b1, 0, 32'h12345678, 1, 2);
        drive(1'b0, 1'b0, '0, '0, 0, 0);
        push("r0_zero_reg", 0, 0);
        push("r0_plain", 4, 32'h12345678);
        push("r0_nodrop", 3, 0);
        drain();
        tick();

        // same-cycle write and read of register 9
        drive(1'b0, 1'b1, 9, 32'hCAFEF00D, 9, 9);
`ifdef BANCO_BYPASS_EN
        push("r9_same", 0, 32'hCAFEF00D);
`else
        push("r9_same", 0, 32'h0);
`endif
        drain();
        tick();
        drive(1'b0, 1'b0, '0, '0, 9, 9);
        push("r9_next", 0, 32'hCAFEF00D);
        drain();
        tick();

        // fill r1..r31 then read every register back
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, ADDR_W'(i),
                  WIDTH'(i) * 32'h01010101 + 32'h80000000,
                  ADDR_W'(i - 1), ADDR_W'(i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
        end

        // one-cycle reset mid-run with a colliding write
        cycle(1'b1, 1'b1, 3, 32'hFFFFFFFF, 3, 4);
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b0, 1'b0, '0, '0, ADDR_W'(k), ADDR_W'(k));
            if (k == 1) begin
                push("rdy_drop", 2, 0);
                push("rdy_drop_n", 6, 0);
                push("rst_nodrop", 3, 0);
                push("clr_rd_forced", 4, 0);
            end
            drain();
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(i));
            if (i == 0) push("rdy_back", 6, 1);
            push("post_rst_z", 0, 0);
            push("post_rst_n", 4, 0);
            drain();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
